// File: rtl/fptd_pkg.sv
// Shared types, constants and the symmetric LLR clip used by the FPTD LLR loader.
package fptd_pkg;

  localparam int NTERM = 3;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } loader_state_t;

  // The most-negative code of a K-bit word is reserved by the decoder for -inf.
  function automatic logic signed [31:0] sat_llr(input logic signed [31:0] x, input int k);
    logic signed [31:0] lim;
    lim = (32'sd1 <<< (k - 1)) - 32'sd1;
    if (x > lim) begin
      return lim;
    end else if (x < -lim) begin
      return -lim;
    end
    return x;
  endfunction

endpackage

// File: rtl/fptd_llr_loader_sat.sv
// Combinational symmetric clip of a W-bit signed LLR into K bits.
module llr_saturate
  import fptd_pkg::*;
#(
  parameter int W = 8,
  parameter int K = 6
) (
  input  logic signed [W-1:0] din,
  output logic signed [K-1:0] dout
);

  logic signed [31:0] wide;

  assign wide = sat_llr(32'(din), K);
  assign dout = K'(wide);

endmodule

// File: rtl/fptd_llr_loader.sv
// Serial-to-parallel LLR frame loader: fills a shadow bank one trellis step per
// cycle and hands complete frames to the decoder through a double-buffered output bank.
module fptd_llr_loader
  import fptd_pkg::*;
#(
  parameter int FL = 104,
  parameter int N  = 6,
  parameter int M  = 6,
  parameter int W  = 8
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        In_Valid,
  output logic                        In_Ready,
  input  logic [W-1:0]                In_Sys,
  input  logic [W-1:0]                In_Par,
  input  logic                        In_Bit,
  input  logic                        In_Last,
  output logic                        Frame_Valid,
  input  logic                        Frame_Ack,
  output logic                        Frame_Error,
  output logic [FL-1:0]               b1_ideal,
  output logic [FL*M-1:0]             ba1,
  output logic [(FL+NTERM)*N-1:0]     ba2,
  output logic [NTERM*N-1:0]          bt1
);

  localparam int STEPS = FL + NTERM;
  localparam int CW    = $clog2(STEPS);
  localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);
  localparam logic [CW-1:0] FL_CNT   = CW'(FL);

  loader_state_t state_q, state_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          fv_q, fv_d;
  logic          err_q, err_d;
  logic          pend_q, pend_d;

  logic [FL-1:0]           sh_bit_q, sh_bit_d;
  logic [FL*M-1:0]         sh_ba1_q, sh_ba1_d;
  logic [STEPS*N-1:0]      sh_ba2_q, sh_ba2_d;
  logic [NTERM*N-1:0]      sh_bt1_q, sh_bt1_d;

  logic [FL-1:0]           out_bit_q, out_bit_d;
  logic [FL*M-1:0]         out_ba1_q, out_ba1_d;
  logic [STEPS*N-1:0]      out_ba2_q, out_ba2_d;
  logic [NTERM*N-1:0]      out_bt1_q, out_bt1_d;

  logic signed [M-1:0] sys_m;
  logic signed [N-1:0] sys_n;
  logic signed [N-1:0] par_n;

  logic take;
  logic at_last;
  logic err_step;
  logic done;
  logic ack;
  logic copy;

  llr_saturate #(.W(W), .K(M)) u_sat_sys_m (.din($signed(In_Sys)), .dout(sys_m));
  llr_saturate #(.W(W), .K(N)) u_sat_sys_n (.din($signed(In_Sys)), .dout(sys_n));
  llr_saturate #(.W(W), .K(N)) u_sat_par_n (.din($signed(In_Par)), .dout(par_n));

  assign take     = In_Valid & In_Ready;
  assign at_last  = (cnt_q == LAST_CNT);
  assign err_step = take & (In_Last ^ at_last);
  assign done     = take & In_Last & at_last;
  assign ack      = Frame_Ack & fv_q;
  // Copy one cycle after completion, or straight away when a held frame is released.
  assign copy     = pend_q | ((state_q == HOLD) & ack);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (done && fv_q && !Frame_Ack) state_d = HOLD;
      HOLD:    if (Frame_Ack) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    In_Ready = (state_q == FILL) && !Reset;
  end

  always_comb begin
    cnt_d     = cnt_q;
    fv_d      = fv_q;
    err_d     = 1'b0;
    pend_d    = 1'b0;
    sh_bit_d  = sh_bit_q;
    sh_ba1_d  = sh_ba1_q;
    sh_ba2_d  = sh_ba2_q;
    sh_bt1_d  = sh_bt1_q;
    out_bit_d = out_bit_q;
    out_ba1_d = out_ba1_q;
    out_ba2_d = out_ba2_q;
    out_bt1_d = out_bt1_q;

    if (take) begin
      if (cnt_q < FL_CNT) begin
        sh_ba1_d[int'(cnt_q)*M +: M] = sys_m;
        sh_bit_d[cnt_q]              = In_Bit;
      end else begin
        sh_bt1_d[(int'(cnt_q) - FL)*N +: N] = sys_n;
      end
      sh_ba2_d[int'(cnt_q)*N +: N] = par_n;
    end

    if (err_step) begin
      cnt_d = '0;
      err_d = 1'b1;
    end else if (done) begin
      cnt_d  = '0;
      pend_d = !fv_q || Frame_Ack;
    end else if (take) begin
      cnt_d = cnt_q + CW'(1);
    end

    // A completion acked in the same cycle keeps Frame_Valid up across the swap.
    if (ack && !done) begin
      fv_d = 1'b0;
    end

    if (copy) begin
      out_bit_d = sh_bit_q;
      out_ba1_d = sh_ba1_q;
      out_ba2_d = sh_ba2_q;
      out_bt1_d = sh_bt1_q;
      fv_d      = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q     <= '0;
      fv_q      <= 1'b0;
      err_q     <= 1'b0;
      pend_q    <= 1'b0;
      sh_bit_q  <= '0;
      sh_ba1_q  <= '0;
      sh_ba2_q  <= '0;
      sh_bt1_q  <= '0;
      out_bit_q <= '0;
      out_ba1_q <= '0;
      out_ba2_q <= '0;
      out_bt1_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      fv_q      <= fv_d;
      err_q     <= err_d;
      pend_q    <= pend_d;
      sh_bit_q  <= sh_bit_d;
      sh_ba1_q  <= sh_ba1_d;
      sh_ba2_q  <= sh_ba2_d;
      sh_bt1_q  <= sh_bt1_d;
      out_bit_q <= out_bit_d;
      out_ba1_q <= out_ba1_d;
      out_ba2_q <= out_ba2_d;
      out_bt1_q <= out_bt1_d;
    end
  end

  assign Frame_Valid = fv_q;
  assign Frame_Error = err_q;
  assign b1_ideal    = out_bit_q;
  assign ba1         = out_ba1_q;
  assign ba2         = out_ba2_q;
  assign bt1         = out_bt1_q;

endmodule

// File: tb/tb_fptd_llr_loader.sv
// Scoreboard bench for fptd_llr_loader: frames are modelled when driven and compared when presented.
module tb_fptd_llr_loader;

  localparam int FL = 104;
  localparam int N  = 6;
  localparam int M  = 6;
  localparam int W  = 8;
  localparam int ST = FL + 3;
  localparam int FW = FL + FL*M + ST*N + 3*N;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, in_valid, in_ready, in_bit, in_last;
  logic             frame_valid, frame_ack, frame_error;
  logic [W-1:0]     in_sys, in_par;
  logic [FL-1:0]    b1_ideal;
  logic [FL*M-1:0]  ba1;
  logic [ST*N-1:0]  ba2;
  logic [3*N-1:0]   bt1;
  logic [FW-1:0]    act_frame;

  assign act_frame = {b1_ideal, ba1, ba2, bt1};

  int n_cmp = 0;
  int n_bad = 0;

  int f_sys[ST];
  int f_par[ST];
  bit f_bit[ST];

  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] exp_f;
  logic [FW-1:0] held_f;
  int            idx;

  fptd_llr_loader #(.FL(FL), .N(N), .M(M), .W(W)) dut (
    .Clock      (clk),
    .Reset      (rst),
    .In_Valid   (in_valid),
    .In_Ready   (in_ready),
    .In_Sys     (in_sys),
    .In_Par     (in_par),
    .In_Bit     (in_bit),
    .In_Last    (in_last),
    .Frame_Valid(frame_valid),
    .Frame_Ack  (frame_ack),
    .Frame_Error(frame_error),
    .b1_ideal   (b1_ideal),
    .ba1        (ba1),
    .ba2        (ba2),
    .bt1        (bt1)
  );

  function automatic int sat(input int x, input int k);
    int lim;
    lim = (1 << (k - 1)) - 1;
    if (x > lim) return lim;
    if (x < -lim) return -lim;
    return x;
  endfunction

  function automatic logic [FW-1:0] model_frame();
    logic [FL-1:0]   eb;
    logic [FL*M-1:0] e1;
    logic [ST*N-1:0] e2;
    logic [3*N-1:0]  et;
    for (int k = 0; k < FL; k++) begin
      e1[k*M +: M] = M'(sat(f_sys[k], M));
      eb[k]        = f_bit[k];
    end
    for (int k = 0; k < ST; k++) e2[k*N +: N] = N'(sat(f_par[k], N));
    for (int t = 0; t < 3; t++) et[t*N +: N] = N'(sat(f_sys[FL+t], N));
    return {eb, e1, e2, et};
  endfunction

  function automatic int first_diff(input logic [FW-1:0] a, input logic [FW-1:0] b);
    for (int i = 0; i < FW; i++) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] win(input logic [FW-1:0] v, input int i);
    int lo;
    lo = (i > FW - 32) ? FW - 32 : ((i < 0) ? 0 : i);
    return v[lo +: 32];
  endfunction

  task automatic gen_ramp();
    for (int k = 0; k < ST; k++) begin
      f_sys[k] = k;
      f_par[k] = k;
      f_bit[k] = bit'(k % 2);
    end
  endtask

  task automatic gen_rand();
    for (int k = 0; k < ST; k++) begin
      f_sys[k] = int'($urandom_range(0, 255)) - 128;
      f_par[k] = int'($urandom_range(0, 255)) - 128;
      f_bit[k] = bit'($urandom_range(0, 1));
    end
  endtask

  task automatic push_frame();
    exp_q.push_back(model_frame());
  endtask

  task automatic send_step(input int k, input logic last, input logic ack_with);
    logic ok;
    int   budget;
    in_valid  = 1'b1;
    in_sys    = W'(f_sys[k]);
    in_par    = W'(f_par[k]);
    in_bit    = f_bit[k];
    in_last   = last;
    frame_ack = ack_with;
    budget    = 0;
    forever begin
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      budget++;
      if (budget > 2000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL step_accept: step %0d In_Ready=%b after %0d cycles, required 1", k, in_ready, budget);
        break;
      end
    end
    frame_ack = 1'b0;
  endtask

  task automatic send_frame(input int n_steps, input int last_at, input logic ack_last);
    for (int k = 0; k < n_steps; k++)
      send_step(k, k == last_at, ack_last && (k == n_steps - 1));
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic ack_pulse();
    frame_ack = 1'b1;
    @(posedge clk);
    #1;
    frame_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: In_Ready=%b required 0", in_ready); end
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: Frame_Valid=%b required 0", frame_valid); end
    n_cmp++; if (frame_error !== 1'b0) begin n_bad++; $display("FAIL reset_error: Frame_Error=%b required 0", frame_error); end
    n_cmp++; if (act_frame !== '0) begin idx = first_diff(act_frame, '0); n_bad++;
      $display("FAIL reset_bank: bit %0d act=%h required=%h", idx, win(act_frame, idx), 32'h0); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: In_Ready=%b required 1", in_ready); end
  endtask

  task automatic test_ramp();
    gen_ramp();
    push_frame();
    send_frame(ST, ST - 1, 1'b0);
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL ramp_latency: Frame_Valid=%b required 0 on the completion edge", frame_valid); end
    @(posedge clk);
    #1;
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL ramp_valid: Frame_Valid=%b required 1", frame_valid); end
    exp_f = exp_q.pop_front();
    n_cmp++; if (act_frame !== exp_f) begin idx = first_diff(act_frame, exp_f); n_bad++;
      $display("FAIL ramp_bank: bit %0d act=%h required=%h", idx, win(act_frame, idx), win(exp_f, idx)); end
    n_cmp++; if (bt1 !== {3{6'b011111}}) begin n_bad++; $display("FAIL ramp_bt1: bt1=%h required=%h", bt1, {3{6'b011111}}); end
    held_f = exp_f;
    ack_pulse();
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL ramp_ack_drop: Frame_Valid=%b required 0", frame_valid); end
    n_cmp++; if (act_frame !== held_f) begin idx = first_diff(act_frame, held_f); n_bad++;
      $display("FAIL ramp_hold_after_ack: bit %0d act=%h required=%h", idx, win(act_frame, idx), win(held_f, idx)); end
    ack_pulse();
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL stray_ack: Frame_Valid=%b required 0", frame_valid); end
  endtask

  task automatic test_saturation();
    int n32;
    gen_rand();
    for (int k = 0; k < ST; k += 2) begin
      f_sys[k] = -128;
      f_par[k] = 127;
    end
    f_sys[1] = -32; f_par[1] = 32;
    f_sys[3] = -31; f_par[3] = 31;
    f_sys[FL+1] = -32;
    push_frame();
    send_frame(ST, ST - 1, 1'b0);
    @(posedge clk);
    #1;
    exp_f = exp_q.pop_front();
    n_cmp++; if (act_frame !== exp_f) begin idx = first_diff(act_frame, exp_f); n_bad++;
      $display("FAIL sat_bank: bit %0d act=%h required=%h", idx, win(act_frame, idx), win(exp_f, idx)); end
    n_cmp++; if (ba1[5:0] !== 6'b100001) begin n_bad++; $display("FAIL sat_ba1_neg: ba1[0]=%b required 100001", ba1[5:0]); end
    n_cmp++; if (ba2[5:0] !== 6'b011111) begin n_bad++; $display("FAIL sat_ba2_pos: ba2[0]=%b required 011111", ba2[5:0]); end
    n32 = 0;
    for (int k = 0; k < FL; k++) if (ba1[k*M +: M] === 6'b100000) n32++;
    for (int k = 0; k < ST; k++) if (ba2[k*N +: N] === 6'b100000) n32++;
    for (int t = 0; t < 3; t++) if (bt1[t*N +: N] === 6'b100000) n32++;
    n_cmp++; if (n32 != 0) begin n_bad++; $display("FAIL sat_no_minus32: %0d fields hold -32, required 0", n32); end
    ack_pulse();
  endtask

  task automatic test_back_to_back();
    gen_rand();
    push_frame();
    send_frame(ST, ST - 1, 1'b0);
    gen_rand();
    push_frame();
    send_frame(ST, ST - 1, 1'b0);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_hold_ready: In_Ready=%b required 0", in_ready); end
    exp_f = exp_q.pop_front();
    held_f = exp_f;
    n_cmp++; if (act_frame !== exp_f) begin idx = first_diff(act_frame, exp_f); n_bad++;
      $display("FAIL b2b_first: bit %0d act=%h required=%h", idx, win(act_frame, idx), win(exp_f, idx)); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_stall: In_Ready=%b required 0", in_ready); end
    n_cmp++; if (act_frame !== held_f) begin idx = first_diff(act_frame, held_f); n_bad++;
      $display("FAIL b2b_stable: bit %0d act=%h required=%h", idx, win(act_frame, idx), win(held_f, idx)); end
    frame_ack = 1'b1;
    @(posedge clk);
    #1;
    frame_ack = 1'b0;
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid_kept: Frame_Valid=%b required 1", frame_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_after_ack: In_Ready=%b required 1", in_ready); end
    exp_f = exp_q.pop_front();
    n_cmp++; if (act_frame !== exp_f) begin idx = first_diff(act_frame, exp_f); n_bad++;
      $display("FAIL b2b_second: bit %0d act=%h required=%h", idx, win(act_frame, idx), win(exp_f, idx)); end
    ack_pulse();
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_final_ack: Frame_Valid=%b required 0", frame_valid); end
  endtask

  task automatic test_same_cycle();
    gen_rand();
    push_frame();
    send_frame(ST, ST - 1, 1'b0);
    @(posedge clk);
    #1;
    exp_f = exp_q.pop_front();
    n_cmp++; if (act_frame !== exp_f) begin idx = first_diff(act_frame, exp_f); n_bad++;
      $display("FAIL same_first: bit %0d act=%h required=%h", idx, win(act_frame, idx), win(exp_f, idx)); end
    gen_rand();
    push_frame();
    send_frame(ST, ST - 1, 1'b1);
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL same_valid_swap: Frame_Valid=%b required 1", frame_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL same_no_hold: In_Ready=%b required 1", in_ready); end
    @(posedge clk);
    #1;
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL same_valid_after: Frame_Valid=%b required 1", frame_valid); end
    exp_f = exp_q.pop_front();
    n_cmp++; if (act_frame !== exp_f) begin idx = first_diff(act_frame, exp_f); n_bad++;
      $display("FAIL same_second: bit %0d act=%h required=%h", idx, win(act_frame, idx), win(exp_f, idx)); end
    ack_pulse();
  endtask

  task automatic test_errors();
    gen_rand();
    push_frame();
    send_frame(ST, ST - 1, 1'b0);
    @(posedge clk);
    #1;
    held_f = exp_q.pop_front();
    n_cmp++; if (act_frame !== held_f) begin idx = first_diff(act_frame, held_f); n_bad++;
      $display("FAIL err_base: bit %0d act=%h required=%h", idx, win(act_frame, idx), win(held_f, idx)); end
    gen_rand();
    send_frame(51, 50, 1'b0);
    n_cmp++; if (frame_error !== 1'b1) begin n_bad++; $display("FAIL err_early_pulse: Frame_Error=%b required 1", frame_error); end
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL err_early_valid: Frame_Valid=%b required 1", frame_valid); end
    n_cmp++; if (act_frame !== held_f) begin idx = first_diff(act_frame, held_f); n_bad++;
      $display("FAIL err_early_bank: bit %0d act=%h required=%h", idx, win(act_frame, idx), win(held_f, idx)); end
    @(posedge clk);
    #1;
    n_cmp++; if (frame_error !== 1'b0) begin n_bad++; $display("FAIL err_early_once: Frame_Error=%b required 0", frame_error); end
    gen_rand();
    send_frame(ST, -1, 1'b0);
    n_cmp++; if (frame_error !== 1'b1) begin n_bad++; $display("FAIL err_missing_pulse: Frame_Error=%b required 1", frame_error); end
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL err_missing_valid: Frame_Valid=%b required 1", frame_valid); end
    n_cmp++; if (act_frame !== held_f) begin idx = first_diff(act_frame, held_f); n_bad++;
      $display("FAIL err_missing_bank: bit %0d act=%h required=%h", idx, win(act_frame, idx), win(held_f, idx)); end
    @(posedge clk);
    #1;
    n_cmp++; if (frame_error !== 1'b0) begin n_bad++; $display("FAIL err_missing_once: Frame_Error=%b required 0", frame_error); end
    ack_pulse();
    gen_rand();
    push_frame();
    send_frame(ST, ST - 1, 1'b0);
    @(posedge clk);
    #1;
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL err_recover_valid: Frame_Valid=%b required 1", frame_valid); end
    exp_f = exp_q.pop_front();
    n_cmp++; if (act_frame !== exp_f) begin idx = first_diff(act_frame, exp_f); n_bad++;
      $display("FAIL err_recover_bank: bit %0d act=%h required=%h", idx, win(act_frame, idx), win(exp_f, idx)); end
    ack_pulse();
  endtask

  task automatic test_reset_mid();
    gen_rand();
    push_frame();
    send_frame(ST, ST - 1, 1'b0);
    @(posedge clk);
    #1;
    exp_f = exp_q.pop_front();
    n_cmp++; if (act_frame !== exp_f) begin idx = first_diff(act_frame, exp_f); n_bad++;
      $display("FAIL rstmid_base: bit %0d act=%h required=%h", idx, win(act_frame, idx), win(exp_f, idx)); end
    gen_rand();
    send_frame(60, -1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: Frame_Valid=%b required 0", frame_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_ready: In_Ready=%b required 0", in_ready); end
    n_cmp++; if (act_frame !== '0) begin idx = first_diff(act_frame, '0); n_bad++;
      $display("FAIL rstmid_bank: bit %0d act=%h required=%h", idx, win(act_frame, idx), 32'h0); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready_after: In_Ready=%b required 1", in_ready); end
    gen_rand();
    push_frame();
    send_frame(ST, ST - 1, 1'b0);
    n_cmp++; if (frame_error !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_error: Frame_Error=%b required 0", frame_error); end
    @(posedge clk);
    #1;
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_reload_valid: Frame_Valid=%b required 1", frame_valid); end
    exp_f = exp_q.pop_front();
    n_cmp++; if (act_frame !== exp_f) begin idx = first_diff(act_frame, exp_f); n_bad++;
      $display("FAIL rstmid_reload_bank: bit %0d act=%h required=%h", idx, win(act_frame, idx), win(exp_f, idx)); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, %0d compared / %0d mismatched so far", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sys    = '0;
    in_par    = '0;
    in_bit    = 1'b0;
    in_last   = 1'b0;
    frame_ack = 1'b0;
    test_reset();
    test_ramp();
    test_saturation();
    test_back_to_back();
    test_same_cycle();
    test_errors();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d frames left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
